// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for inter-stage pipeline registers: occupancy state encoding
// and the payload field layout that producer and consumer stages pack/unpack with.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // Payload layout, LSB first: IR | PC | PC+8 | ALU | MULDIV | RD | WE | JMP
    localparam int IR_OFF     = 0;
    localparam int IR_W       = 32;
    localparam int PC_OFF     = IR_OFF + IR_W;
    localparam int PC_W       = 32;
    localparam int PC8_OFF    = PC_OFF + PC_W;
    localparam int PC8_W      = 32;
    localparam int ALU_OFF    = PC8_OFF + PC8_W;
    localparam int ALU_W      = 32;
    localparam int MULDIV_OFF = ALU_OFF + ALU_W;
    localparam int MULDIV_W   = 64;
    localparam int RD_OFF     = MULDIV_OFF + MULDIV_W;
    localparam int RD_W       = 5;
    localparam int WE_OFF     = RD_OFF + RD_W;
    localparam int WE_W       = 1;
    localparam int JMP_OFF    = WE_OFF + WE_W;
    localparam int JMP_W      = 1;
    localparam int PAYLOAD_W  = JMP_OFF + JMP_W;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, flush, optional 2-entry
// skid buffer (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = 199,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int                SKID       = 1,
    parameter int                CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_DATA;
            skid_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push && (SKID != 0)) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Ready derived from next state so it is a pure flop, no path from out_ready
            logic rdy_q;
            always_ff @(posedge clk) begin
                if (!reset)
                    rdy_q <= 1'b1;
                else
                    rdy_q <= (state_d != ST_TWO);
            end
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (out_valid && !out_ready && !flush),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, non-skid mode and counter saturation.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // dut1: SKID=1, nonzero reset payload
    logic       v1, r1_in, ov1, or1, f1;
    logic [7:0] d1, od1;
    logic [31:0] sc1;
    logic [1:0] oc1;

    // dut0: SKID=0
    logic       v0, r0_in, ov0, or0, f0;
    logic [7:0] d0, od0;
    logic [31:0] sc0;
    logic [1:0] oc0;

    // dut2: SKID=1, 4-bit stall counter
    logic       v2, r2_in, ov2, or2, f2;
    logic [7:0] d2, od2;
    logic [3:0] sc2;
    logic [1:0] oc2;

    pipe_stage_reg #(.DATA_W(8), .RESET_DATA(8'hA5), .SKID(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1_in), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .flush(f1),
        .stall_cnt(sc1), .occupancy(oc1));

    pipe_stage_reg #(.DATA_W(8), .RESET_DATA(8'h00), .SKID(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_ready(r0_in), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .flush(f0),
        .stall_cnt(sc0), .occupancy(oc0));

    pipe_stage_reg #(.DATA_W(8), .RESET_DATA(8'h00), .SKID(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2_in), .in_data(d2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(f2),
        .stall_cnt(sc2), .occupancy(oc2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        v1 = 1'b1; d1 = 8'h05; or1 = 1'b0; f1 = 1'b0;
        v0 = 1'b1; d0 = 8'h05; or0 = 1'b0; f0 = 1'b0;
        v2 = 1'b1; d2 = 8'h05; or2 = 1'b0; f2 = 1'b0;

        // Reset held two cycles with a beat offered
        step();
        step();
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_out_data",  od1, 8'hA5);
        chk("rst_in_ready",  r1_in, 1'b1);
        chk("rst_stall_cnt", sc1, 32'd0);
        chk("rst_occupancy", oc1, 2'd0);
        chk("rst_in_ready_noskid", r0_in, 1'b1);
        chk("rst_out_valid_noskid", ov0, 1'b0);
        v0 = 1'b0; v2 = 1'b0;
        reset = 1'b1;

        // Streaming 1..8 with out_ready high
        or1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v1 = 1'b1; d1 = 8'(i);
            step();
            chk($sformatf("stream_data_%0d", i), od1, 8'(i));
            chk($sformatf("stream_ready_%0d", i), r1_in, 1'b1);
            chk($sformatf("stream_occ_%0d", i), oc1, 2'd1);
        end
        v1 = 1'b0;
        step();
        chk("stream_drain_occ", oc1, 2'd0);
        chk("stream_stall", sc1, 32'd0);

        // Backpressure: 0xA, 0xB accepted, 0xC held upstream
        or1 = 1'b0; v1 = 1'b1; d1 = 8'h0A;
        step();
        chk("bp_occ_a", oc1, 2'd1);
        chk("bp_ready_a", r1_in, 1'b1);
        chk("bp_stall_a", sc1, 32'd0);
        d1 = 8'h0B;
        step();
        chk("bp_occ_b", oc1, 2'd2);
        chk("bp_ready_b", r1_in, 1'b0);
        chk("bp_data_b", od1, 8'h0A);
        chk("bp_stall_b", sc1, 32'd1);
        d1 = 8'h0C;
        step();
        chk("bp_occ_c", oc1, 2'd2);
        chk("bp_hold_c", od1, 8'h0A);
        chk("bp_stall_c", sc1, 32'd2);
        step();
        chk("bp_stall_c2", sc1, 32'd3);

        // Release: drains 0xA, 0xB, 0xC in order
        or1 = 1'b1;
        step();
        chk("rel_data_b", od1, 8'h0B);
        chk("rel_occ_b", oc1, 2'd1);
        chk("rel_ready_b", r1_in, 1'b1);
        step();
        chk("rel_data_c", od1, 8'h0C);
        chk("rel_occ_c", oc1, 2'd1);
        v1 = 1'b0;
        step();
        chk("rel_occ_end", oc1, 2'd0);
        chk("rel_stall_end", sc1, 32'd3);

        // Flush with two beats held and a push/pop in the same cycle
        or1 = 1'b0; v1 = 1'b1; d1 = 8'h0A;
        step();
        d1 = 8'h0B;
        step();
        chk("fl_pre_occ", oc1, 2'd2);
        chk("fl_pre_stall", sc1, 32'd4);
        f1 = 1'b1; d1 = 8'h0C; or1 = 1'b1;
        step();
        chk("fl_out_valid", ov1, 1'b0);
        chk("fl_occ", oc1, 2'd0);
        chk("fl_data", od1, 8'hA5);
        chk("fl_ready", r1_in, 1'b1);
        chk("fl_stall", sc1, 32'd4);
        f1 = 1'b0; v1 = 1'b0;
        step();
        chk("fl_no_c_valid", ov1, 1'b0);
        chk("fl_no_c_occ", oc1, 2'd0);

        // SKID=0: combinational in_ready from out_ready
        v0 = 1'b1; d0 = 8'h11; or0 = 1'b0;
        step();
        chk("ns_data_11", od0, 8'h11);
        d0 = 8'h22;
        #1;
        chk("ns_ready_low", r0_in, 1'b0);
        step();
        chk("ns_hold_11", od0, 8'h11);
        chk("ns_occ", oc0, 2'd1);
        chk("ns_stall", sc0, 32'd1);
        or0 = 1'b1;
        #1;
        chk("ns_ready_high", r0_in, 1'b1);
        step();
        chk("ns_data_22", od0, 8'h22);
        chk("ns_occ_22", oc0, 2'd1);
        v0 = 1'b0;
        step();
        chk("ns_drain", oc0, 2'd0);

        // Saturation with a 4-bit counter
        v2 = 1'b1; d2 = 8'h33; or2 = 1'b0;
        step();
        v2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) chk("sat_mid", sc2, 4'd10);
        end
        chk("sat_20", sc2, 4'd15);
        step(); step(); step();
        chk("sat_hold", sc2, 4'd15);
        chk("sat_data", od2, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
